// File: rtl/jstk_pkg.sv
// jstk_pkg: shared FSM encoding, frame layout and deadzone helper for the
// PmodJSTK sampler and anything else that decodes its DOUT frame.
package jstk_pkg;

    // Sampler FSM states, 3-bit encoding.
    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_REQ        = 3'd1,
        ST_WAIT_START = 3'd2,
        ST_WAIT_DONE  = 3'd3,
        ST_CAPTURE    = 3'd4,
        ST_ABORT      = 3'd5
    } state_t;

    // Axis value reported when the stick is at rest.
    localparam logic [9:0] CENTRE = 10'd512;

    // DOUT frame layout: X/Y low bytes, X/Y high bits, button bits.
    localparam int FRAME_W  = 40;
    localparam int X_LO_MSB = 39;
    localparam int X_LO_LSB = 32;
    localparam int X_HI_MSB = 25;
    localparam int X_HI_LSB = 24;
    localparam int Y_LO_MSB = 23;
    localparam int Y_LO_LSB = 16;
    localparam int Y_HI_MSB = 9;
    localparam int Y_HI_LSB = 8;
    localparam int BTN_MSB  = 2;
    localparam int BTN_LSB  = 0;

    // One decoded joystick sample.
    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
        logic [2:0] buttons;
    } sample_t;

    // Snap an axis to CENTRE when it lies strictly inside the deadzone.
    // A deadzone of 0 leaves the raw value untouched.
    function automatic logic [9:0] apply_deadzone(input logic [9:0] raw, input int deadzone);
        logic signed [10:0] diff;
        logic [10:0]        mag;
        diff = $signed({1'b0, raw}) - $signed({1'b0, CENTRE});
        mag  = diff[10] ? -diff : diff;
        if (deadzone > 0 && int'(mag) < deadzone) begin
            return CENTRE;
        end
        return raw;
    endfunction

endpackage

// File: rtl/jstk_decode.sv
// jstk_decode: combinational DOUT frame -> {x, y, buttons} with centre deadzone.
module jstk_decode
    import jstk_pkg::*;
#(
    parameter int DEADZONE = 16
) (
    input  logic [FRAME_W-1:0] frame,
    output sample_t            sample
);

    logic [9:0] raw_x;
    logic [9:0] raw_y;

    // Bits of the frame that carry no joystick information.
    logic unused_bits;
    assign unused_bits = ^{frame[31:26], frame[15:10], frame[7:3]};

    // Reassemble the 10-bit axes and apply the deadzone.
    always_comb begin
        // NOTE: every output is assigned on every pass, so no latch can be inferred.
        raw_x          = {frame[X_HI_MSB:X_HI_LSB], frame[X_LO_MSB:X_LO_LSB]};
        raw_y          = {frame[Y_HI_MSB:Y_HI_LSB], frame[Y_LO_MSB:Y_LO_LSB]};
        sample.x       = apply_deadzone(raw_x, DEADZONE);
        sample.y       = apply_deadzone(raw_y, DEADZONE);
        sample.buttons = frame[BTN_MSB:BTN_LSB];
    end

endmodule

// File: rtl/jstk_sampler.sv
// jstk_sampler: periodically requests a PmodJSTK transfer, follows the SS
// envelope to find its end, then captures and decodes the DOUT frame.
module jstk_sampler
    import jstk_pkg::*;
#(
    parameter int POLL_CYCLES    = 1000000,
    parameter int REQ_CYCLES     = 3000,
    parameter int TIMEOUT_CYCLES = 200000,
    parameter int DEADZONE       = 16
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               enable,
    input  logic               ss_in,
    input  logic [FRAME_W-1:0] jstk_dout,
    output logic               snd_rec,
    output logic [9:0]         x_pos,
    output logic [9:0]         y_pos,
    output logic [2:0]         buttons,
    output logic               sample_valid,
    output logic               new_sample,
    input  logic               rd_ack,
    output logic               timeout_err,
    output logic [15:0]        sample_count
);

    localparam int POLL_W  = $clog2(POLL_CYCLES);
    localparam int TMR_MAX = (REQ_CYCLES > TIMEOUT_CYCLES) ? REQ_CYCLES : TIMEOUT_CYCLES;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);
    localparam int SND_W   = $clog2(REQ_CYCLES + 1);

    localparam logic [POLL_W-1:0] POLL_LAST    = POLL_W'(POLL_CYCLES - 1);
    localparam logic [TMR_W-1:0]  REQ_LAST     = TMR_W'(REQ_CYCLES - 1);
    localparam logic [TMR_W-1:0]  TIMEOUT_LAST = TMR_W'(TIMEOUT_CYCLES - 1);
    localparam logic [SND_W-1:0]  SND_LAST     = SND_W'(REQ_CYCLES - 1);

    state_t            state;
    logic [TMR_W-1:0]  tmr;
    logic [SND_W-1:0]  snd_cnt;
    logic [POLL_W-1:0] poll_cnt;
    logic              ss_meta;
    logic              ss_sync;
    logic              ss_sync_d;
    logic              tick;
    logic              ss_fall;
    logic              ss_rise;
    sample_t           decoded;

    assign tick    = (poll_cnt == POLL_LAST);
    assign ss_fall = ss_sync_d & ~ss_sync;
    assign ss_rise = ~ss_sync_d & ss_sync;

    jstk_decode #(
        .DEADZONE (DEADZONE)
    ) u_decode (
        .frame  (jstk_dout),
        .sample (decoded)
    );

    // Two-flop synchroniser for SS plus a delayed copy for edge detection.
    always_ff @(posedge CLK) begin
        // NOTE: non-blocking assignments so each flop takes the previous stage's old value.
        if (RST) begin
            ss_meta   <= 1'b1;
            ss_sync   <= 1'b1;
            ss_sync_d <= 1'b1;
        end else begin
            ss_meta   <= ss_in;
            ss_sync   <= ss_meta;
            ss_sync_d <= ss_sync;
        end
    end

    // Free-running poll counter; tick is asserted on its last count.
    always_ff @(posedge CLK) begin
        if (RST) begin
            poll_cnt <= '0;
        end else if (tick) begin
            poll_cnt <= '0;
        end else begin
            poll_cnt <= poll_cnt + 1'b1;
        end
    end

    // Transaction FSM with registered outputs and sticky status flags.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state        <= ST_IDLE;
            tmr          <= '0;
            snd_cnt      <= '0;
            snd_rec      <= 1'b0;
            x_pos        <= CENTRE;
            y_pos        <= CENTRE;
            buttons      <= 3'b000;
            sample_valid <= 1'b0;
            new_sample   <= 1'b0;
            timeout_err  <= 1'b0;
            sample_count <= 16'd0;
        end else begin
            sample_valid <= 1'b0;
            tmr          <= tmr + 1'b1;

            // snd_rec runs its own window so an early SS fall does not cut it short.
            if (snd_rec) begin
                if (snd_cnt == SND_LAST) begin
                    snd_rec <= 1'b0;
                end else begin
                    snd_cnt <= snd_cnt + 1'b1;
                end
            end

            // NOTE: the clears come before the case so a set in the same cycle overrides them.
            if (rd_ack) begin
                new_sample  <= 1'b0;
                timeout_err <= 1'b0;
            end

            case (state)
                ST_IDLE: begin
                    tmr <= '0;
                    if (tick && enable) begin
                        state   <= ST_REQ;
                        snd_rec <= 1'b1;
                        snd_cnt <= '0;
                    end
                end
                ST_REQ: begin
                    if (ss_fall) begin
                        state <= ST_WAIT_DONE;
                        tmr   <= '0;
                    end else if (tmr == REQ_LAST) begin
                        state <= ST_WAIT_START;
                        tmr   <= '0;
                    end
                end
                ST_WAIT_START: begin
                    if (ss_fall) begin
                        state <= ST_WAIT_DONE;
                        tmr   <= '0;
                    end else if (tmr == TIMEOUT_LAST) begin
                        state       <= ST_ABORT;
                        tmr         <= '0;
                        snd_rec     <= 1'b0;
                        timeout_err <= 1'b1;
                    end
                end
                ST_WAIT_DONE: begin
                    if (ss_rise) begin
                        // Outputs are loaded on entry so they are valid during CAPTURE.
                        state        <= ST_CAPTURE;
                        tmr          <= '0;
                        x_pos        <= decoded.x;
                        y_pos        <= decoded.y;
                        buttons      <= decoded.buttons;
                        sample_valid <= 1'b1;
                        new_sample   <= 1'b1;
                        sample_count <= sample_count + 16'd1;
                    end else if (tmr == TIMEOUT_LAST) begin
                        state       <= ST_ABORT;
                        tmr         <= '0;
                        snd_rec     <= 1'b0;
                        timeout_err <= 1'b1;
                    end
                end
                ST_CAPTURE: begin
                    state <= ST_IDLE;
                    tmr   <= '0;
                end
                ST_ABORT: begin
                    state   <= ST_IDLE;
                    tmr     <= '0;
                    snd_rec <= 1'b0;
                end
                default: begin
                    state <= ST_IDLE;
                    tmr   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_jstk_sampler.sv
// tb_jstk_sampler: directed bench for jstk_sampler with a PmodJSTK SS model.
module tb_jstk_sampler;

    localparam int POLL     = 5000;
    localparam int REQ      = 30;
    localparam int TIMEOUT  = 400;
    localparam int SS_DELAY = 4;
    localparam int SS_LOW   = 60;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        enable = 1'b0;
    logic        ss_in = 1'b1;
    logic [39:0] jstk_dout = 40'd0;
    logic        rd_ack = 1'b0;
    logic        snd_rec;
    logic [9:0]  x_pos;
    logic [9:0]  y_pos;
    logic [2:0]  buttons;
    logic        sample_valid;
    logic        new_sample;
    logic        timeout_err;
    logic [15:0] sample_count;

    int checks = 0;
    int errors = 0;

    // Behavioural PmodJSTK: answers a snd_rec rise with an SS-low window.
    logic slave_present = 1'b1;
    logic snd_q = 1'b0;
    bit   m_busy = 1'b0;
    int   m_cnt = 0;

    jstk_sampler #(
        .POLL_CYCLES    (POLL),
        .REQ_CYCLES     (REQ),
        .TIMEOUT_CYCLES (TIMEOUT),
        .DEADZONE       (16)
    ) dut (
        .CLK          (CLK),
        .RST          (RST),
        .enable       (enable),
        .ss_in        (ss_in),
        .jstk_dout    (jstk_dout),
        .snd_rec      (snd_rec),
        .x_pos        (x_pos),
        .y_pos        (y_pos),
        .buttons      (buttons),
        .sample_valid (sample_valid),
        .new_sample   (new_sample),
        .rd_ack       (rd_ack),
        .timeout_err  (timeout_err),
        .sample_count (sample_count)
    );

    always #5 CLK = ~CLK;

    always @(negedge CLK) begin
        if (RST) begin
            ss_in  = 1'b1;
            m_busy = 1'b0;
            m_cnt  = 0;
        end else if (!m_busy) begin
            if (snd_rec && !snd_q && slave_present) begin
                m_busy = 1'b1;
                m_cnt  = 0;
            end
        end else begin
            m_cnt++;
            if (m_cnt == SS_DELAY) begin
                ss_in = 1'b0;
            end else if (m_cnt == SS_DELAY + SS_LOW) begin
                ss_in  = 1'b1;
                m_busy = 1'b0;
            end
        end
        snd_q = snd_rec;
    end

    // Wait for a sample_valid pulse; drops rd_ack on the cycle it is seen.
    task automatic wait_sample(output bit got);
        got = 1'b0;
        for (int i = 0; i < 2 * POLL; i++) begin
            @(negedge CLK);
            if (sample_valid) begin
                rd_ack = 1'b0;
                got = 1'b1;
                break;
            end
        end
    endtask

    // Wait until the model has pulled SS low.
    task automatic wait_ss_low(output bit got);
        got = 1'b0;
        for (int i = 0; i < 2 * POLL; i++) begin
            @(negedge CLK);
            if (!ss_in) begin
                got = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge CLK);
        RST = 1'b0;
        @(negedge CLK);
        checks++; if (snd_rec !== 1'b0) begin errors++; $display("FAIL reset_snd_rec got %b want 0", snd_rec); end
        checks++; if (x_pos !== 10'd512) begin errors++; $display("FAIL reset_x got %0d want 512", x_pos); end
        checks++; if (y_pos !== 10'd512) begin errors++; $display("FAIL reset_y got %0d want 512", y_pos); end
        checks++; if (buttons !== 3'b000) begin errors++; $display("FAIL reset_buttons got %b want 000", buttons); end
        checks++; if (sample_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", sample_valid); end
        checks++; if (new_sample !== 1'b0) begin errors++; $display("FAIL reset_new got %b want 0", new_sample); end
        checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL reset_timeout got %b want 0", timeout_err); end
        checks++; if (sample_count !== 16'd0) begin errors++; $display("FAIL reset_count got %0d want 0", sample_count); end
        enable = 1'b1;
    endtask

    task automatic test_frame();
        bit got;
        int extra;
        jstk_dout = 40'h2C_03_90_01_05;
        wait_sample(got);
        checks++; if (!got) begin errors++; $display("FAIL frame_wait got no sample want sample_valid"); end
        checks++; if (x_pos !== 10'h32C) begin errors++; $display("FAIL frame_x got %h want 32c", x_pos); end
        checks++; if (y_pos !== 10'h190) begin errors++; $display("FAIL frame_y got %h want 190", y_pos); end
        checks++; if (buttons !== 3'b101) begin errors++; $display("FAIL frame_buttons got %b want 101", buttons); end
        checks++; if (sample_count !== 16'd1) begin errors++; $display("FAIL frame_count got %0d want 1", sample_count); end
        checks++; if (new_sample !== 1'b1) begin errors++; $display("FAIL frame_new got %b want 1", new_sample); end
        extra = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge CLK);
            if (sample_valid) extra++;
        end
        checks++; if (extra != 0) begin errors++; $display("FAIL frame_pulse_width got %0d extra valid cycles want 0", extra); end
    endtask

    task automatic test_deadzone();
        bit got;
        // X=520, Y=500: both inside the deadzone.
        jstk_dout = 40'h08_02_F4_01_00;
        wait_sample(got);
        checks++; if (!got) begin errors++; $display("FAIL dz1_wait got no sample want sample_valid"); end
        checks++; if (x_pos !== 10'd512) begin errors++; $display("FAIL dz1_x got %0d want 512", x_pos); end
        checks++; if (y_pos !== 10'd512) begin errors++; $display("FAIL dz1_y got %0d want 512", y_pos); end
        // X=528 (d=+16) and Y=496 (d=-16): both exactly on the edge, kept raw.
        jstk_dout = 40'h10_02_F0_01_00;
        wait_sample(got);
        checks++; if (!got) begin errors++; $display("FAIL dz2_wait got no sample want sample_valid"); end
        checks++; if (x_pos !== 10'd528) begin errors++; $display("FAIL dz2_x got %0d want 528", x_pos); end
        checks++; if (y_pos !== 10'd496) begin errors++; $display("FAIL dz2_y got %0d want 496", y_pos); end
        checks++; if (sample_count !== 16'd3) begin errors++; $display("FAIL dz_count got %0d want 3", sample_count); end
    endtask

    task automatic test_timeout();
        bit got;
        int t;
        int hi;
        int sv;
        slave_present = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 2 * POLL; i++) begin
            @(negedge CLK);
            if (snd_rec) begin
                got = 1'b1;
                break;
            end
        end
        checks++; if (!got) begin errors++; $display("FAIL to_request got no snd_rec want snd_rec"); end
        t = 0;
        hi = 0;
        sv = 0;
        got = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            if (snd_rec) hi++;
            if (sample_valid) sv++;
            if (timeout_err) begin
                got = 1'b1;
                break;
            end
            @(negedge CLK);
            t++;
        end
        checks++; if (!got) begin errors++; $display("FAIL to_flag got timeout_err=0 want 1"); end
        checks++; if (t != 430) begin errors++; $display("FAIL to_latency got %0d want 430", t); end
        checks++; if (hi != 30) begin errors++; $display("FAIL to_snd_rec_width got %0d want 30", hi); end
        checks++; if (sv != 0) begin errors++; $display("FAIL to_no_valid got %0d want 0", sv); end
        checks++; if (x_pos !== 10'd528 || y_pos !== 10'd496 || buttons !== 3'b000)
            begin errors++; $display("FAIL to_outputs got %0d/%0d/%b want 528/496/000", x_pos, y_pos, buttons); end
        checks++; if (sample_count !== 16'd3) begin errors++; $display("FAIL to_count got %0d want 3", sample_count); end
        slave_present = 1'b1;
        jstk_dout = 40'h2C_03_90_01_05;
        wait_sample(got);
        checks++; if (!got) begin errors++; $display("FAIL to_resume got no sample want sample_valid"); end
        checks++; if (sample_count !== 16'd4) begin errors++; $display("FAIL to_resume_count got %0d want 4", sample_count); end
        checks++; if (timeout_err !== 1'b1) begin errors++; $display("FAIL to_sticky got %b want 1", timeout_err); end
    endtask

    task automatic test_rd_ack();
        bit got;
        @(negedge CLK);
        rd_ack = 1'b1;
        @(negedge CLK);
        rd_ack = 1'b0;
        checks++; if (new_sample !== 1'b0) begin errors++; $display("FAIL ack_clear_new got %b want 0", new_sample); end
        checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL ack_clear_to got %b want 0", timeout_err); end
        // Hold rd_ack through the capture so it coincides with the set.
        rd_ack = 1'b1;
        wait_sample(got);
        checks++; if (!got) begin errors++; $display("FAIL ack_wait got no sample want sample_valid"); end
        checks++; if (new_sample !== 1'b1) begin errors++; $display("FAIL ack_set_wins got %b want 1", new_sample); end
        @(negedge CLK);
        checks++; if (new_sample !== 1'b1) begin errors++; $display("FAIL ack_hold got %b want 1", new_sample); end
        rd_ack = 1'b1;
        @(negedge CLK);
        rd_ack = 1'b0;
        checks++; if (new_sample !== 1'b0) begin errors++; $display("FAIL ack_lone got %b want 0", new_sample); end
        checks++; if (sample_count !== 16'd5) begin errors++; $display("FAIL ack_count got %0d want 5", sample_count); end
    endtask

    task automatic test_reset_mid();
        bit got;
        jstk_dout = 40'h2C_03_90_01_05;
        wait_ss_low(got);
        checks++; if (!got) begin errors++; $display("FAIL rst_ss_low got none want ss_in low"); end
        repeat (5) @(negedge CLK);
        checks++; if (snd_rec !== 1'b1) begin errors++; $display("FAIL rst_pre_snd_rec got %b want 1", snd_rec); end
        RST = 1'b1;
        @(negedge CLK);
        checks++; if (snd_rec !== 1'b0) begin errors++; $display("FAIL rst_snd_rec got %b want 0", snd_rec); end
        checks++; if (x_pos !== 10'd512 || y_pos !== 10'd512 || buttons !== 3'b000)
            begin errors++; $display("FAIL rst_outputs got %0d/%0d/%b want 512/512/000", x_pos, y_pos, buttons); end
        checks++; if (sample_count !== 16'd0) begin errors++; $display("FAIL rst_count got %0d want 0", sample_count); end
        checks++; if (new_sample !== 1'b0 || timeout_err !== 1'b0 || sample_valid !== 1'b0)
            begin errors++; $display("FAIL rst_flags got %b%b%b want 000", new_sample, timeout_err, sample_valid); end
        RST = 1'b0;
        wait_sample(got);
        checks++; if (!got) begin errors++; $display("FAIL rst_post_wait got no sample want sample_valid"); end
        checks++; if (x_pos !== 10'h32C || y_pos !== 10'h190 || buttons !== 3'b101)
            begin errors++; $display("FAIL rst_post_outputs got %h/%h/%b want 32c/190/101", x_pos, y_pos, buttons); end
        checks++; if (sample_count !== 16'd1) begin errors++; $display("FAIL rst_post_count got %0d want 1", sample_count); end
    endtask

    task automatic test_enable_wrap();
        bit got;
        int reqs;
        // X=0x1A5, Y=0x25A, all buttons pressed.
        jstk_dout = 40'hA5_01_5A_02_07;
        wait_ss_low(got);
        checks++; if (!got) begin errors++; $display("FAIL en_ss_low got none want ss_in low"); end
        repeat (5) @(negedge CLK);
        enable = 1'b0;
        wait_sample(got);
        checks++; if (!got) begin errors++; $display("FAIL en_complete got no sample want sample_valid"); end
        checks++; if (x_pos !== 10'h1A5 || y_pos !== 10'h25A || buttons !== 3'b111)
            begin errors++; $display("FAIL en_outputs got %h/%h/%b want 1a5/25a/111", x_pos, y_pos, buttons); end
        checks++; if (sample_count !== 16'd2) begin errors++; $display("FAIL en_count got %0d want 2", sample_count); end
        reqs = 0;
        for (int i = 0; i < 3 * POLL; i++) begin
            @(negedge CLK);
            if (snd_rec) reqs++;
        end
        checks++; if (reqs != 0) begin errors++; $display("FAIL en_no_request got %0d snd_rec cycles want 0", reqs); end
        force dut.sample_count = 16'hFFFF;
        @(negedge CLK);
        release dut.sample_count;
        enable = 1'b1;
        wait_sample(got);
        checks++; if (!got) begin errors++; $display("FAIL wrap_wait got no sample want sample_valid"); end
        checks++; if (sample_count !== 16'd0) begin errors++; $display("FAIL wrap_count got %h want 0000", sample_count); end
    endtask

    initial begin
        test_reset();
        test_frame();
        test_deadzone();
        test_timeout();
        test_rd_ack();
        test_reset_mid();
        test_enable_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
